// File: rtl/maxpool2d.sv
// Streaming 2x2 stride-2 max-pool over a signed raster feature map.
// Row/column parity selects hold, pair-store, hold, pair-emit; one half-width row buffer spans row pairs.
module maxpool2d #(
  parameter int LineWidthPx = 158,
  parameter int LineCountPx = 118,
  parameter int Width       = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic signed [Width-1:0] data_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic signed [Width-1:0] data_o
);

  localparam int PoolW = LineWidthPx / 2;
  localparam int PoolH = LineCountPx / 2;
  localparam int XW    = $clog2(LineWidthPx + 1);
  localparam int YW    = $clog2(LineCountPx + 1);
  localparam int IdxW  = (PoolW > 1) ? $clog2(PoolW) : 1;

  localparam logic [XW-1:0] LastX   = XW'(LineWidthPx - 1);
  localparam logic [YW-1:0] LastY   = YW'(LineCountPx - 1);
  localparam logic [XW-1:0] PooledX = XW'(2 * PoolW);
  localparam logic [YW-1:0] PooledY = YW'(2 * PoolH);

  logic [XW-1:0]           xPos_q, xPos_d;
  logic [YW-1:0]           yPos_q, yPos_d;
  logic signed [Width-1:0] hold_q;
  logic signed [Width-1:0] rowBuf_q [PoolW];
  logic                    validOut_q;
  logic signed [Width-1:0] dataOut_q;

  logic                    inFire;
  logic                    colPooled;
  logic                    rowPooled;
  logic                    produce;
  logic                    bufWrite;
  logic [IdxW-1:0]         bufIdx;
  logic signed [Width-1:0] bufRd;
  logic signed [Width-1:0] pairMax;
  logic signed [Width-1:0] result;

  assign ready_o = ~validOut_q | ready_i;
  assign valid_o = validOut_q;
  assign data_o  = dataOut_q;
  assign inFire  = valid_i & ready_o;

  // A trailing odd column or row falls outside the pooled region and is simply swallowed.
  assign colPooled = (xPos_q < PooledX);
  assign rowPooled = (yPos_q < PooledY);
  assign bufIdx    = xPos_q[IdxW:1];
  assign bufRd     = rowBuf_q[bufIdx];
  assign pairMax   = (data_i > hold_q) ? data_i : hold_q;
  assign result    = (bufRd > pairMax) ? bufRd : pairMax;
  assign produce   = inFire & colPooled & rowPooled & xPos_q[0] & yPos_q[0];
  assign bufWrite  = inFire & colPooled & rowPooled & xPos_q[0] & ~yPos_q[0];

  always_comb begin
    xPos_d = xPos_q;
    yPos_d = yPos_q;
    if (inFire) begin
      if (xPos_q == LastX) begin
        xPos_d = '0;
        yPos_d = (yPos_q == LastY) ? '0 : yPos_q + 1'b1;
      end else begin
        xPos_d = xPos_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      xPos_q     <= '0;
      yPos_q     <= '0;
      hold_q     <= '0;
      validOut_q <= 1'b0;
      dataOut_q  <= '0;
    end else begin
      xPos_q <= xPos_d;
      yPos_q <= yPos_d;
      if (inFire && !xPos_q[0]) begin
        hold_q <= data_i;
      end
      if (ready_o) begin
        validOut_q <= produce;
      end
      if (produce) begin
        dataOut_q <= result;
      end
    end
  end

  // Never cleared: every entry is rewritten on an even row before the odd row reads it.
  always_ff @(posedge clk_i) begin
    if (bufWrite) begin
      rowBuf_q[bufIdx] <= pairMax;
    end
  end

endmodule

// File: tb/tb_maxpool2d.sv
// Self-checking bench for maxpool2d: several geometries, each compared against a window-max model.
module tb_maxpool2d;

  localparam int NumDut = 5;
  localparam int DutW[NumDut] = '{4, 2, 5, 8, 158};
  localparam int DutH[NumDut] = '{4, 2, 5, 6, 118};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic vi  = 1'b0;
  logic ri  = 1'b1;
  logic signed [31:0] di = '0;

  logic viG [NumDut];
  logic ro  [NumDut];
  logic vo  [NumDut];
  logic signed [31:0] dout [NumDut];

  int cur       = 0;
  int readyMode = 0;
  int gapPct    = 0;
  bit fullRate  = 1'b0;

  int testsRun    = 0;
  int testsFailed = 0;
  int outCount    = 0;
  int roLowCount  = 0;
  bit holdPending = 1'b0;
  int holdVal     = 0;

  int frameQ[$];
  int expQ[$];

  for (genvar g = 0; g < NumDut; g++) begin : gDut
    assign viG[g] = vi && (cur == g);
    maxpool2d #(
      .LineWidthPx(DutW[g]),
      .LineCountPx(DutH[g]),
      .Width(32)
    ) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .valid_i(viG[g]),
      .ready_o(ro[g]),
      .data_i (di),
      .valid_o(vo[g]),
      .ready_i(ri),
      .data_o (dout[g])
    );
  end

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int got, input int exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Downstream ready: 0 = always ready, 1 = coin flip each cycle, 2 = stalled.
  always @(posedge clk) begin
    #1;
    if (readyMode == 0) ri = 1'b1;
    else if (readyMode == 1) ri = 1'($urandom_range(1));
    else ri = 1'b0;
  end

  // Scoreboard: each accepted output must be the next modelled value; held outputs must not move.
  always @(negedge clk) begin
    if (!rst) begin
      if (vo[cur] && ri) begin
        checkOutput("outAvailable", int'(expQ.size() > 0), 1);
        if (expQ.size() > 0) checkOutput("pooled", dout[cur], expQ.pop_front());
        outCount++;
      end
      if (vo[cur] && !ri) begin
        if (holdPending) checkOutput("holdStable", dout[cur], holdVal);
        holdPending = 1'b1;
        holdVal     = dout[cur];
      end else begin
        holdPending = 1'b0;
      end
      if (fullRate && !ro[cur]) roLowCount++;
    end
  end

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic applyStimulus(input int x, input int y, input int w, input int h, input int v);
    int waited = 0;
    bit done   = 1'b0;
    bit isBR   = (x % 2 == 1) && (y % 2 == 1) && (x < 2 * (w / 2)) && (y < 2 * (h / 2));
    while (gapPct > 0 && $urandom_range(99) < gapPct) begin
      vi = 1'b0;
      @(posedge clk); #1;
    end
    vi = 1'b1;
    di = v;
    while (!done && waited < 1000) begin
      @(negedge clk);
      if (ro[cur]) done = 1'b1;
      @(posedge clk); #1;
      waited++;
    end
    vi = 1'b0;
    if (!done) checkOutput("inputTimeout", waited, 0);
    else if (readyMode == 0) checkOutput("latency", int'(vo[cur]), int'(isBR));
  endtask

  // Reference: every complete 2x2 window of the frame, in raster order of windows.
  task automatic runFrame(input int w, input int h);
    for (int py = 0; py < h / 2; py++) begin
      for (int px = 0; px < w / 2; px++) begin
        int base = 2 * py * w + 2 * px;
        expQ.push_back(max2(max2(frameQ[base], frameQ[base + 1]),
                            max2(frameQ[base + w], frameQ[base + w + 1])));
      end
    end
    for (int i = 0; i < w * h; i++) applyStimulus(i % w, i / w, w, h, frameQ[i]);
  endtask

  task automatic fillSeq(input int n, input int first);
    frameQ.delete();
    for (int i = 0; i < n; i++) frameQ.push_back(first + i);
  endtask

  task automatic fillRand(input int n);
    frameQ.delete();
    for (int i = 0; i < n; i++) frameQ.push_back(int'($urandom));
  endtask

  task automatic drain();
    int n = 0;
    while (expQ.size() > 0 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drainEmpty", expQ.size(), 0);
    readyMode = 0;
    gapPct    = 0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int outStart;
    rst = 1'b1;
    #12;
    checkOutput("rstValid", int'(vo[0]), 0);
    checkOutput("rstData", dout[0], 0);
    checkOutput("rstReady", int'(ro[0]), 1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    cur = 0;
    fillSeq(16, 1);
    runFrame(4, 4);
    drain();

    cur = 1;
    frameQ = '{-5, -3, -8, -1};
    runFrame(2, 2);
    frameQ = '{-2147483647 - 1, 0, -1, -7};
    runFrame(2, 2);
    frameQ = '{4, 4, 4, 4};
    runFrame(2, 2);
    drain();

    cur = 2;
    for (int f = 0; f < 2; f++) begin
      fillSeq(25, 0);
      runFrame(5, 5);
    end
    drain();

    cur = 3;
    readyMode = 1;
    gapPct    = 30;
    for (int f = 0; f < 3; f++) begin
      fillRand(48);
      runFrame(8, 6);
    end
    drain();

    cur = 0;
    readyMode = 2;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) applyStimulus(i % 4, i / 4, 4, 4, 100 + i);
    checkOutput("preRstValid", int'(vo[0]), 1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checkOutput("midRstValid", int'(vo[0]), 0);
    checkOutput("midRstData", dout[0], 0);
    checkOutput("midRstReady", int'(ro[0]), 1);
    @(negedge clk) rst = 1'b0;
    readyMode = 0;
    @(posedge clk); #1;
    outStart = outCount;
    fillRand(16);
    runFrame(4, 4);
    drain();
    checkOutput("postRstCount", outCount - outStart, 4);

    cur = 4;
    outStart   = outCount;
    roLowCount = 0;
    fullRate   = 1'b1;
    for (int f = 0; f < 2; f++) begin
      fillRand(158 * 118);
      runFrame(158, 118);
    end
    fullRate = 1'b0;
    drain();
    checkOutput("fullRateCount", outCount - outStart, 2 * 79 * 59);
    checkOutput("fullRateReadyLow", roLowCount, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
